sec60_counter: RTL and testbench

Downstream consumer of the mod-6 divider stage. It edge-detects the divider's `y` output, which is a square wave with one rising edge per 12 clocks, and turns each rising edge into a one-cycle tick. A run/hold FSM gates the ticks into a two-digit BCD 00–59 counter. The counter emits a one-cycle `wrap` pulse on 59→00 so a further stage (minutes) can be chained.

---
 rtl/sec60_pkg.sv | 16 +
 rtl/sec60_counter_bcd_digit.sv | 48 ++++
 rtl/sec60_counter.sv | 123 ++++++++++++
 tb/tb_sec60_counter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sec60_pkg.sv
// Shared definitions for the seconds counter: FSM state encoding and
// default digit limits/widths.
package sec60_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int unsigned ONES_MAX_DEF = 32'd9;
    localparam int unsigned TENS_MAX_DEF = 32'd5;
    localparam int unsigned ONES_W       = 32'd4;
    localparam int unsigned TENS_W       = 32'd3;

endpackage

// File: rtl/sec60_counter_bcd_digit.sv
// One BCD digit counting 0..MAX with clear priority over increment;
// carry is combinational so digits chain within a single clock.
module bcd_digit #(
    parameter int unsigned MAX = 32'd9,
    parameter int unsigned W   = 32'd4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] val,
    output logic         carry
);

    logic [W-1:0] val_q;
    logic [W-1:0] val_d;
    logic         at_max_s;

    assign at_max_s = (val_q == W'(MAX));
    assign carry    = inc & at_max_s;
    assign val      = val_q;

    // Next digit value: explicit compare against MAX, never overflow-wrap
    always_comb begin
        val_d = val_q;
        if (clr) begin
            val_d = '0;
        end else if (inc) begin
            if (at_max_s) begin
                val_d = '0;
            end else begin
                val_d = val_q + {{(W-1){1'b0}}, 1'b1};
            end
        end else begin
            val_d = val_q;
        end
    end

    // Digit register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

endmodule

// File: rtl/sec60_counter.sv
// Seconds counter: edge-detects the divider output into ticks, gates them
// with a run/hold FSM into a chained BCD 00..59 count with a wrap pulse.
module sec60_counter
    import sec60_pkg::*;
#(
    parameter int unsigned ONES_MAX = ONES_MAX_DEF,
    parameter int unsigned TENS_MAX = TENS_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              y,
    input  logic              start,
    input  logic              stop,
    input  logic              clr,
    output logic [ONES_W-1:0] ones,
    output logic [TENS_W-1:0] tens,
    output logic              wrap,
    output logic              running
);

    state_e state_q;
    state_e state_d;
    logic   y_d_q;
    logic   tick_q;
    logic   tick_d;
    logic   wrap_q;
    logic   wrap_d;
    logic   running_q;
    logic   running_d;
    logic   adv_s;
    logic   ones_carry_s;
    logic   tens_carry_s;

    // y_d resets high so a y already high at reset release is not an edge
    assign tick_d = y & ~y_d_q;

    // Edge-detect registers; the tick is registered, so the count moves one edge after y is seen high
    always_ff @(posedge clk) begin
        if (!rst) begin
            y_d_q  <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            y_d_q  <= y;
            tick_q <= tick_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: stop dominates start from every state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_RUN, ST_HOLD: begin
                if (stop) begin
                    state_d = ST_HOLD;
                end else if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: tick is judged against the pre-transition state
    always_comb begin
        adv_s     = 1'b0;
        running_d = 1'b0;
        case (state_q)
            ST_RUN:  adv_s = tick_q;
            default: adv_s = 1'b0;
        endcase
        if (state_d == ST_RUN) begin
            running_d = 1'b1;
        end else begin
            running_d = 1'b0;
        end
    end

    bcd_digit #(.MAX(ONES_MAX), .W(ONES_W)) u_ones (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (adv_s),
        .val   (ones),
        .carry (ones_carry_s)
    );

    bcd_digit #(.MAX(TENS_MAX), .W(TENS_W)) u_tens (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (ones_carry_s),
        .val   (tens),
        .carry (tens_carry_s)
    );

    assign wrap_d = tens_carry_s & ~clr;

    // Registered wrap and running flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            wrap_q    <= wrap_d;
            running_q <= running_d;
        end
    end

    assign wrap    = wrap_q;
    assign running = running_q;

endmodule

// File: tb/tb_sec60_counter.sv
// Self-checking bench for sec60_counter: constant vector table, directed
// corner sequences and randomized stimulus against a seconds-level model.
module tb_sec60_counter;

    logic       clk = 1'b0;
    logic       rst, y, start, stop, clr;
    logic [3:0] ones;
    logic [2:0] tens;
    logic       wrap, running;

    int errors = 0;
    int checks = 0;

    // Reference model: count held as plain seconds 0..59, mode 0=idle 1=run 2=hold
    int m_cnt  = 0;
    int m_mode = 0;
    bit m_yprev = 1'b1;
    bit m_tick  = 1'b0;
    bit m_wrap  = 1'b0;

    typedef struct {
        bit r; bit yy; bit sa; bit so; bit cl;
        int e_ones; int e_tens; bit e_wrap; bit e_run;
    } vec_t;
    vec_t vecs[12];

    always #5 clk = ~clk;

    sec60_counter dut (
        .clk(clk), .rst(rst), .y(y), .start(start), .stop(stop), .clr(clr),
        .ones(ones), .tens(tens), .wrap(wrap), .running(running)
    );

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit yy, input bit sa, input bit so, input bit cl);
        bit adv;
        @(negedge clk);
        rst = r; y = yy; start = sa; stop = so; clr = cl;
        if (!r) begin
            m_yprev = 1'b1; m_tick = 1'b0; m_mode = 0; m_cnt = 0; m_wrap = 1'b0;
        end else begin
            adv    = m_tick && (m_mode == 1);
            m_wrap = !cl && adv && (m_cnt == 59);
            if (cl)       m_cnt = 0;
            else if (adv) m_cnt = (m_cnt + 1) % 60;
            if (so)       m_mode = 2;
            else if (sa)  m_mode = 1;
            m_tick  = yy && !m_yprev;
            m_yprev = yy;
        end
        @(posedge clk);
        #1;
        check("model", {23'd0, ones, tens, wrap, running},
              {23'd0, 4'(m_cnt % 10), 3'(m_cnt / 10), m_wrap, (m_mode == 1)});
    endtask

    // One divider period: 6 clocks high, 6 low; returns wraps seen
    task automatic period(output int wraps);
        wraps = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, (i < 6), 1'b0, 1'b0, 1'b0);
            if (wrap) wraps++;
        end
    endtask

    task automatic reset_and_start();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic count_to(input int n);
        int w;
        reset_and_start();
        for (int i = 0; i < n; i++) period(w);
    endtask

    initial begin
        int w;
        int wsum;
        rst = 1'b0; y = 1'b0; start = 1'b0; stop = 1'b0; clr = 1'b0;

        //        r  y  sa so cl  ones tens wrap run
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 1, 0, 0, 0, 0, 0, 1};
        vecs[2]  = '{1, 1, 0, 0, 0, 0, 0, 0, 1};
        vecs[3]  = '{1, 1, 0, 0, 0, 1, 0, 0, 1};
        vecs[4]  = '{1, 0, 0, 0, 0, 1, 0, 0, 1};
        vecs[5]  = '{1, 1, 0, 0, 0, 1, 0, 0, 1};
        vecs[6]  = '{1, 1, 0, 1, 0, 2, 0, 0, 0};
        vecs[7]  = '{1, 0, 0, 0, 0, 2, 0, 0, 0};
        vecs[8]  = '{1, 1, 0, 0, 0, 2, 0, 0, 0};
        vecs[9]  = '{1, 1, 1, 0, 0, 2, 0, 0, 1};
        vecs[10] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        vecs[11] = '{1, 0, 1, 1, 0, 0, 0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].r, vecs[i].yy, vecs[i].sa, vecs[i].so, vecs[i].cl);
            check($sformatf("vec%0d", i), {23'd0, ones, tens, wrap, running},
                  {23'd0, 4'(vecs[i].e_ones), 3'(vecs[i].e_tens), vecs[i].e_wrap, vecs[i].e_run});
        end

        // Ten divider periods from 00 reach 10
        count_to(10);
        check("ten_ones", ones, 0);
        check("ten_tens", tens, 1);

        // Free-running full minute: exactly one wrap, back at 00
        reset_and_start();
        wsum = 0;
        for (int i = 0; i < 60; i++) begin
            period(w);
            wsum += w;
        end
        check("minute_wraps", wsum, 1);
        check("minute_count", {ones, tens}, 0);

        // clr together with the tick at 59
        count_to(59);
        check("at59", {25'd0, ones, tens}, {25'd0, 4'd9, 3'd5});
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("clr59_count", {ones, tens}, 0);
        check("clr59_wrap", wrap, 0);

        // start+stop together from IDLE lands in HOLD
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("ss_running", running, 0);
        period(w);
        check("ss_hold_count", {ones, tens}, 0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("ss_start", running, 1);

        // HOLD at 23 across five edges, then resume
        count_to(23);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) period(w);
        check("hold23", {25'd0, ones, tens}, {25'd0, 4'd3, 3'd2});
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        period(w);
        check("resume24", {25'd0, ones, tens}, {25'd0, 4'd4, 3'd2});

        // y high across reset release gives no tick
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("yhigh_noadv", {ones, tens}, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("yhigh_adv", {25'd0, ones, tens}, {25'd0, 4'd1, 3'd0});

        // Reset for one cycle at 41 while running
        count_to(41);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("rst41", {23'd0, ones, tens, wrap, running}, 0);
        period(w);
        period(w);
        check("rst41_idle", {ones, tens}, 0);

        // Randomized stimulus against the model
        reset_and_start();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 499) != 0), $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 99) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
